// File: rtl/checker_pkg.sv
// Shared definitions for the nibble scoreboard: watchdog state encodings and
// default geometry constants.
package checker_pkg;

  localparam int DEF_WIDTH          = 5;
  localparam int DEF_DEPTH          = 8;
  localparam int DEF_CNT_W          = 16;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    WD_IDLE      = 2'd0,
    WD_WAIT      = 2'd1,
    WD_TIMED_OUT = 2'd2
  } wd_state_t;

endpackage

// File: rtl/chk_fifo.sv
// Synchronous FIFO with full/empty flags and same-cycle push/pop; a push into a
// full FIFO is accepted only when a pop frees the head slot in that cycle.
module chk_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // Extra pointer bit distinguishes full from empty when the indices coincide.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is data only; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/nibble_scoreboard.sv
// In-order masked scoreboard between a conductual and an estructural stream.
// Optional stall watchdog is built only when CHECKER_TIMEOUT_EN is defined.
module nibble_scoreboard
  import checker_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int DEPTH          = DEF_DEPTH,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             VALID_c,
  input  logic [WIDTH-1:0] DATA_OUT_c,
  input  logic             VALID_e,
  input  logic [WIDTH-1:0] DATA_OUT_e,
  input  logic [WIDTH-1:0] COMPARE_MASK,
  input  logic             CLEAR,
  output logic             check_data_out,
  output logic             compare_valid,
  output logic             error_sticky,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [WIDTH-1:0] first_err_c,
  output logic [WIDTH-1:0] first_err_e,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             overflow,
  output logic             timeout
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [WIDTH-1:0] head_c;
  logic [WIDTH-1:0] head_e;
  logic             full_c;
  logic             full_e;
  logic             empty_c;
  logic             empty_e;
  logic             do_cmp;
  logic             cmp_match;
  logic             drop;
  logic             wd_fire;
  logic [CNT_W-1:0] sample_idx;

  chk_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_c (
    .clk       (CLK),
    .rst_n     (RESET_L),
    .push      (VALID_c),
    .push_data (DATA_OUT_c),
    .pop       (do_cmp),
    .head      (head_c),
    .full      (full_c),
    .empty     (empty_c)
  );

  chk_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_e (
    .clk       (CLK),
    .rst_n     (RESET_L),
    .push      (VALID_e),
    .push_data (DATA_OUT_e),
    .pop       (do_cmp),
    .head      (head_e),
    .full      (full_e),
    .empty     (empty_e)
  );

  // Both heads pop together; a pop also makes room for a same-cycle push.
  assign do_cmp    = !empty_c && !empty_e;
  assign cmp_match = (((head_c ^ head_e) & COMPARE_MASK) == '0);
  assign drop      = (VALID_c && full_c && !do_cmp) || (VALID_e && full_e && !do_cmp);

`ifdef CHECKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  wd_state_t     wd_state;
  wd_state_t     wd_state_next;
  logic [TW-1:0] stall_cnt;
  logic [TW-1:0] stall_cnt_next;
  logic          one_sided;

  assign one_sided = empty_c ^ empty_e;

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      wd_state  <= WD_IDLE;
      stall_cnt <= '0;
    end else begin
      wd_state  <= wd_state_next;
      stall_cnt <= stall_cnt_next;
    end
  end

  always_comb begin
    wd_state_next  = wd_state;
    stall_cnt_next = stall_cnt;
    wd_fire        = 1'b0;
    if (CLEAR) begin
      wd_state_next  = WD_IDLE;
      stall_cnt_next = '0;
    end else begin
      case (wd_state)
        WD_IDLE, WD_WAIT: begin
          if (one_sided) begin
            stall_cnt_next = stall_cnt + 1'b1;
            if (stall_cnt_next == TW'(TIMEOUT_CYCLES)) begin
              wd_state_next = WD_TIMED_OUT;
              wd_fire       = 1'b1;
            end else begin
              wd_state_next = WD_WAIT;
            end
          end else begin
            wd_state_next  = WD_IDLE;
            stall_cnt_next = '0;
          end
        end
        WD_TIMED_OUT: wd_state_next = WD_TIMED_OUT;
        default: begin
          wd_state_next  = WD_IDLE;
          stall_cnt_next = '0;
        end
      endcase
    end
  end

  assign timeout = (wd_state == WD_TIMED_OUT);
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  // Stage boundary: comparison result and statistics registered at the pop edge.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      check_data_out <= 1'b1;
      compare_valid  <= 1'b0;
      error_sticky   <= 1'b0;
      match_count    <= '0;
      mismatch_count <= '0;
      first_err_c    <= '0;
      first_err_e    <= '0;
      first_err_idx  <= '0;
      overflow       <= 1'b0;
      sample_idx     <= '0;
    end else begin
      compare_valid <= do_cmp;
      if (do_cmp) check_data_out <= cmp_match;
      if (CLEAR) begin
        error_sticky   <= 1'b0;
        match_count    <= '0;
        mismatch_count <= '0;
        first_err_c    <= '0;
        first_err_e    <= '0;
        first_err_idx  <= '0;
        overflow       <= 1'b0;
        sample_idx     <= '0;
      end else begin
        if (do_cmp) begin
          sample_idx <= sample_idx + 1'b1;
          if (cmp_match) begin
            match_count <= sat_inc(match_count);
          end else begin
            mismatch_count <= sat_inc(mismatch_count);
            error_sticky   <= 1'b1;
            if (mismatch_count == '0) begin
              first_err_c   <= head_c;
              first_err_e   <= head_e;
              first_err_idx <= sample_idx;
            end
          end
        end
        if (drop) begin
          overflow     <= 1'b1;
          error_sticky <= 1'b1;
        end
        if (wd_fire) error_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nibble_scoreboard.sv
// Directed self-checking bench for nibble_scoreboard (default parameters).
module tb_nibble_scoreboard;

  logic        CLK = 1'b0;
  logic        RESET_L;
  logic        VALID_c;
  logic [4:0]  DATA_OUT_c;
  logic        VALID_e;
  logic [4:0]  DATA_OUT_e;
  logic [4:0]  COMPARE_MASK;
  logic        CLEAR;
  logic        check_data_out;
  logic        compare_valid;
  logic        error_sticky;
  logic [15:0] match_count;
  logic [15:0] mismatch_count;
  logic [4:0]  first_err_c;
  logic [4:0]  first_err_e;
  logic [15:0] first_err_idx;
  logic        overflow;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  nibble_scoreboard dut (
    .CLK            (CLK),
    .RESET_L        (RESET_L),
    .VALID_c        (VALID_c),
    .DATA_OUT_c     (DATA_OUT_c),
    .VALID_e        (VALID_e),
    .DATA_OUT_e     (DATA_OUT_e),
    .COMPARE_MASK   (COMPARE_MASK),
    .CLEAR          (CLEAR),
    .check_data_out (check_data_out),
    .compare_valid  (compare_valid),
    .error_sticky   (error_sticky),
    .match_count    (match_count),
    .mismatch_count (mismatch_count),
    .first_err_c    (first_err_c),
    .first_err_e    (first_err_e),
    .first_err_idx  (first_err_idx),
    .overflow       (overflow),
    .timeout        (timeout)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic vc, input logic [4:0] dc, input logic ve, input logic [4:0] de);
    VALID_c    = vc;
    DATA_OUT_c = dc;
    VALID_e    = ve;
    DATA_OUT_e = de;
  endtask

  task automatic do_clear;
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (check_data_out !== 1'b1) begin errors++; $display("FAIL reset_check: got %b expected 1", check_data_out); end
    checks++; if (compare_valid !== 1'b0) begin errors++; $display("FAIL reset_cv: got %b expected 0", compare_valid); end
    checks++; if (error_sticky !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", error_sticky); end
    checks++; if (match_count !== 16'd0 || mismatch_count !== 16'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", match_count, mismatch_count); end
    checks++; if (overflow !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL reset_flags: got ovf=%b to=%b expected 0/0", overflow, timeout); end
    checks++; if (first_err_idx !== 16'd0 || first_err_c !== 5'd0 || first_err_e !== 5'd0) begin errors++; $display("FAIL reset_capture: got %0d %h %h expected 0 0 0", first_err_idx, first_err_c, first_err_e); end
  endtask

  task automatic test_lockstep;
    logic [4:0] d;
    for (int i = 0; i < 10; i++) begin
      d = 5'((i * 7 + 3) % 32);
      drive(1'b1, d, 1'b1, d);
      tick();
    end
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    checks++; if (match_count !== 16'd10) begin errors++; $display("FAIL lockstep_match: got %0d expected 10", match_count); end
    checks++; if (mismatch_count !== 16'd0) begin errors++; $display("FAIL lockstep_mismatch: got %0d expected 0", mismatch_count); end
    checks++; if (check_data_out !== 1'b1) begin errors++; $display("FAIL lockstep_check: got %b expected 1", check_data_out); end
    checks++; if (error_sticky !== 1'b0) begin errors++; $display("FAIL lockstep_err: got %b expected 0", error_sticky); end
    checks++; if (compare_valid !== 1'b1) begin errors++; $display("FAIL lockstep_last_cv: got %b expected 1", compare_valid); end
    tick();
    checks++; if (compare_valid !== 1'b0) begin errors++; $display("FAIL lockstep_idle_cv: got %b expected 0", compare_valid); end
  endtask

  task automatic test_skew;
    logic exp_cv;
    int   ei;
    do_clear();
    for (int t = 0; t < 10; t++) begin
      ei = t - 3;
      drive(t < 6, 5'(16 + t), (t >= 3) && (t < 9), 5'(16 + ei));
      tick();
      exp_cv = (t >= 4) && (t <= 9);
      checks++; if (compare_valid !== exp_cv) begin errors++; $display("FAIL skew_cv_t%0d: got %b expected %b", t, compare_valid, exp_cv); end
    end
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    checks++; if (match_count !== 16'd6 || mismatch_count !== 16'd0) begin errors++; $display("FAIL skew_counts: got %0d/%0d expected 6/0", match_count, mismatch_count); end
  endtask

  task automatic test_mask;
    logic [4:0] dc;
    logic [4:0] de;
    logic [4:0] masks [2];
    masks[0] = 5'h0F;
    masks[1] = 5'h1F;
    for (int m = 0; m < 2; m++) begin
      COMPARE_MASK = masks[m];
      do_clear();
      for (int t = 0; t < 7; t++) begin
        dc = (t == 4) ? 5'h15 : 5'(t);
        de = (t == 4) ? 5'h05 : 5'(t);
        if (t < 6) drive(1'b1, dc, 1'b1, de);
        else       drive(1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        if (m == 1 && t == 5) begin
          checks++; if (check_data_out !== 1'b0) begin errors++; $display("FAIL mask_check_low: got %b expected 0", check_data_out); end
        end
      end
      if (m == 0) begin
        checks++; if (match_count !== 16'd6 || mismatch_count !== 16'd0) begin errors++; $display("FAIL mask0f_counts: got %0d/%0d expected 6/0", match_count, mismatch_count); end
        checks++; if (error_sticky !== 1'b0) begin errors++; $display("FAIL mask0f_err: got %b expected 0", error_sticky); end
      end else begin
        checks++; if (match_count !== 16'd5 || mismatch_count !== 16'd1) begin errors++; $display("FAIL mask1f_counts: got %0d/%0d expected 5/1", match_count, mismatch_count); end
        checks++; if (first_err_c !== 5'h15 || first_err_e !== 5'h05) begin errors++; $display("FAIL mask1f_capture: got %h/%h expected 15/05", first_err_c, first_err_e); end
        checks++; if (first_err_idx !== 16'd4) begin errors++; $display("FAIL mask1f_idx: got %0d expected 4", first_err_idx); end
        checks++; if (error_sticky !== 1'b1) begin errors++; $display("FAIL mask1f_err: got %b expected 1", error_sticky); end
        checks++; if (check_data_out !== 1'b1) begin errors++; $display("FAIL mask1f_check: got %b expected 1", check_data_out); end
      end
    end
  endtask

  task automatic test_overflow;
    COMPARE_MASK = 5'h1F;
    do_clear();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 5'(i), 1'b0, 5'd0);
      tick();
      if (i == 7) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", overflow); end
      end
    end
    checks++; if (overflow !== 1'b1 || error_sticky !== 1'b1) begin errors++; $display("FAIL ovf_flags: got ovf=%b err=%b expected 1/1", overflow, error_sticky); end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 5'd0, 1'b1, 5'(i));
      tick();
    end
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    checks++; if (match_count !== 16'd8 || mismatch_count !== 16'd0) begin errors++; $display("FAIL ovf_drain: got %0d/%0d expected 8/0", match_count, mismatch_count); end
    drive(1'b1, 5'd9, 1'b1, 5'd9);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    checks++; if (match_count !== 16'd9 || mismatch_count !== 16'd0) begin errors++; $display("FAIL ovf_lost9th: got %0d/%0d expected 9/0", match_count, mismatch_count); end
  endtask

  task automatic test_clear;
    COMPARE_MASK = 5'h1F;
    drive(1'b1, 5'd3, 1'b1, 5'd3);
    tick();
    drive(1'b1, 5'd1, 1'b1, 5'd2);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    checks++; if (match_count !== 16'd0 || mismatch_count !== 16'd0) begin errors++; $display("FAIL clear_counts: got %0d/%0d expected 0/0", match_count, mismatch_count); end
    checks++; if (error_sticky !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL clear_flags: got err=%b ovf=%b expected 0/0", error_sticky, overflow); end
    checks++; if (first_err_c !== 5'd0 || first_err_e !== 5'd0 || first_err_idx !== 16'd0) begin errors++; $display("FAIL clear_capture: got %h %h %0d expected 0 0 0", first_err_c, first_err_e, first_err_idx); end
    checks++; if (check_data_out !== 1'b0) begin errors++; $display("FAIL clear_check: got %b expected 0", check_data_out); end
    drive(1'b1, 5'd7, 1'b1, 5'd7);
    tick();
    drive(1'b1, 5'd1, 1'b1, 5'd2);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    checks++; if (match_count !== 16'd1 || mismatch_count !== 16'd1) begin errors++; $display("FAIL clear_after_counts: got %0d/%0d expected 1/1", match_count, mismatch_count); end
    checks++; if (first_err_idx !== 16'd1 || first_err_c !== 5'd1 || first_err_e !== 5'd2) begin errors++; $display("FAIL clear_after_capture: got %0d %h %h expected 1 01 02", first_err_idx, first_err_c, first_err_e); end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(20 + i), 1'b0, 5'd0);
      tick();
    end
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    #2;
    RESET_L = 1'b0;
    #1;
    checks++; if (check_data_out !== 1'b1 || error_sticky !== 1'b0) begin errors++; $display("FAIL arst_flags: got chk=%b err=%b expected 1/0", check_data_out, error_sticky); end
    checks++; if (match_count !== 16'd0 || mismatch_count !== 16'd0 || first_err_idx !== 16'd0) begin errors++; $display("FAIL arst_counts: got %0d/%0d/%0d expected 0/0/0", match_count, mismatch_count, first_err_idx); end
    #1;
    RESET_L = 1'b1;
    drive(1'b0, 5'd0, 1'b1, 5'd9);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    tick();
    checks++; if (compare_valid !== 1'b0 || match_count !== 16'd0) begin errors++; $display("FAIL arst_fifo_empty: got cv=%b match=%0d expected 0/0", compare_valid, match_count); end
    drive(1'b1, 5'd9, 1'b0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    checks++; if (compare_valid !== 1'b1 || match_count !== 16'd1 || mismatch_count !== 16'd0) begin errors++; $display("FAIL arst_resume: got cv=%b %0d/%0d expected 1 1/0", compare_valid, match_count, mismatch_count); end
  endtask

`ifdef CHECKER_TIMEOUT_EN
  task automatic test_timeout;
    do_clear();
    drive(1'b1, 5'd4, 1'b0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    repeat (63) tick();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b expected 0", timeout); end
    tick();
    checks++; if (timeout !== 1'b1 || error_sticky !== 1'b1) begin errors++; $display("FAIL timeout_fire: got to=%b err=%b expected 1/1", timeout, error_sticky); end
    repeat (5) tick();
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_hold: got %b expected 1", timeout); end
    do_clear();
    checks++; if (timeout !== 1'b0 || error_sticky !== 1'b0) begin errors++; $display("FAIL timeout_clear: got to=%b err=%b expected 0/0", timeout, error_sticky); end
  endtask
`endif

  initial begin
    RESET_L      = 1'b0;
    CLEAR        = 1'b0;
    COMPARE_MASK = 5'h1F;
    drive(1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    tick();
    RESET_L = 1'b1;
    tick();
    test_reset();
    test_lockstep();
    test_skew();
    test_mask();
    test_overflow();
    test_clear();
    test_async_reset();
`ifdef CHECKER_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
